// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory port between NREQ cores.
// One winner is latched per access cycle; the memory is driven from the latched copy.
module dmem_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic [2:0]           gnt_id,
  output logic                 busy,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_a,
  output logic [DW-1:0]        mem_wd,
  input  logic [DW-1:0]        mem_rd
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] NREQ4 = 4'(NREQ);
  localparam logic [2:0] LAST  = 3'(NREQ - 1);

  state_t          state, state_n;
  logic [2:0]      ptr;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            lat_we;

  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [2:0]      win;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            win_we;
  logic [3:0]      pos;

  always_comb begin
    gnt_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt_oh[i] = (gnt_id == 3'(i));
    end
  end

  // The grantee still holds req during its ack cycle, so it is masked when leaving BUSY.
  always_comb begin
    elig      = req & ~((state == BUSY) ? gnt_oh : '0);
    found     = 1'b0;
    win       = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= NREQ4) begin
        pos = pos - NREQ4;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && elig[i] && (pos == 4'(i))) begin
          found     = 1'b1;
          win       = 3'(i);
          win_addr  = addr[i*AW +: AW];
          win_wdata = wdata[i*DW +: DW];
          win_we    = we[i];
        end
      end
    end
    state_n = found ? BUSY : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else begin
      state <= state_n;
      if (found) begin
        gnt_id    <= win;
        ptr       <= (win == LAST) ? 3'd0 : win + 3'd1;
        lat_addr  <= win_addr;
        lat_wdata <= win_wdata;
        lat_we    <= win_we;
      end
    end
  end

  always_comb begin
    busy   = (state == BUSY);
    ack    = busy ? gnt_oh : '0;
    mem_we = busy & lat_we;
    mem_a  = lat_addr;
    mem_wd = lat_wdata;
    rdata  = mem_rd;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a 2-requester and a 4-requester instance,
// each with a behavioural word RAM on its memory port.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req2, we2, ack2;
  logic [63:0] addr2, wdata2;
  logic [31:0] rdata2, ma2, mwd2, mrd2;
  logic [2:0]  gnt2;
  logic        busy2, mwe2;
  logic [31:0] ram2 [0:255];

  logic [3:0]   req4, we4, ack4;
  logic [127:0] addr4, wdata4;
  logic [31:0]  rdata4, ma4, mwd4, mrd4;
  logic [2:0]   gnt4;
  logic         busy4, mwe4;
  logic [31:0]  ram4 [0:255];

  dmem_arbiter #(.NREQ(2), .AW(32), .DW(32)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .rdata(rdata2), .gnt_id(gnt2), .busy(busy2), .mem_we(mwe2),
    .mem_a(ma2), .mem_wd(mwd2), .mem_rd(mrd2)
  );

  dmem_arbiter #(.NREQ(4), .AW(32), .DW(32)) u_dut4 (
    .clk(clk), .reset(reset), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .ack(ack4), .rdata(rdata4), .gnt_id(gnt4), .busy(busy4), .mem_we(mwe4),
    .mem_a(ma4), .mem_wd(mwd4), .mem_rd(mrd4)
  );

  assign mrd2 = ram2[ma2[7:0]];
  assign mrd4 = ram4[ma4[7:0]];
  always @(posedge clk) if (mwe2) ram2[ma2[7:0]] = mwd2;
  always @(posedge clk) if (mwe4) ram4[ma4[7:0]] = mwd4;

  typedef struct {
    logic [3:0]  ack;
    logic [2:0]  gid;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t mk(logic [3:0] ack, logic [2:0] gid, logic w,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd);
    exp_t r;
    r.ack = ack; r.gid = gid; r.we = w; r.a = a; r.wd = wd; r.rd = rd;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req2 = '0; we2 = '0; req4 = '0; we4 = '0;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;
    #1 reset = 1'b1;
    #2;
    if (ack2 !== 2'b00) begin fails++; $display("FAIL reset_ack2 got %b want 00", ack2); end
    tests++;
    if (busy2 !== 1'b0) begin fails++; $display("FAIL reset_busy2 got %b want 0", busy2); end
    tests++;
    if (mwe2 !== 1'b0) begin fails++; $display("FAIL reset_mem_we2 got %b want 0", mwe2); end
    tests++;
    if (ma2 !== 32'd0) begin fails++; $display("FAIL reset_mem_a2 got %h want 0", ma2); end
    tests++;
    if (mwd2 !== 32'd0) begin fails++; $display("FAIL reset_mem_wd2 got %h want 0", mwd2); end
    tests++;
    if (gnt2 !== 3'd0) begin fails++; $display("FAIL reset_gnt2 got %0d want 0", gnt2); end
    tests++;
    if (ack4 !== 4'b0000) begin fails++; $display("FAIL reset_ack4 got %b want 0000", ack4); end
    tests++;
    if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    tests++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    if (busy2 !== 1'b0) begin fails++; $display("FAIL idle_no_req got busy %b want 0", busy2); end
    tests++;
  endtask

  task automatic test_single_read();
    int cyc;
    cyc = 0;
    ram2[8] = 32'hDEADBEEF;
    addr2[31:0] = 32'd8; we2 = 2'b00; req2 = 2'b01;
    sbq.push_back(mk(4'b0001, 3'd0, 1'b0, 32'd8, 32'd0, 32'hDEADBEEF));
    for (int c = 0; c < 4 && sbq.size() != 0; c++) begin
      tick();
      cyc++;
      if (ack2 !== 2'b00) begin
        e = sbq.pop_front();
        if (ack2 !== e.ack[1:0]) begin fails++; $display("FAIL rd_ack got %b want %b", ack2, e.ack[1:0]); end
        tests++;
        if (rdata2 !== e.rd) begin fails++; $display("FAIL rd_rdata got %h want %h", rdata2, e.rd); end
        tests++;
        if (mwe2 !== e.we) begin fails++; $display("FAIL rd_mem_we got %b want %b", mwe2, e.we); end
        tests++;
        if (busy2 !== 1'b1) begin fails++; $display("FAIL rd_busy got %b want 1", busy2); end
        tests++;
        req2 = req2 & ~ack2;
      end
    end
    if (sbq.size() != 0) begin fails++; $display("FAIL rd_timeout pending %0d want 0", sbq.size()); sbq.delete(); end
    tests++;
    if (cyc != 1) begin fails++; $display("FAIL rd_latency got %0d want 1", cyc); end
    tests++;
    tick();
    if (busy2 !== 1'b0) begin fails++; $display("FAIL rd_idle_after got busy %b want 0", busy2); end
    tests++;
  endtask

  task automatic test_write_read();
    addr2[63:32] = 32'd4; wdata2[63:32] = 32'h12345678; we2 = 2'b10; req2 = 2'b10;
    sbq.push_back(mk(4'b0010, 3'd1, 1'b1, 32'd4, 32'h12345678, 32'd0));
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 4 && sbq.size() != 0; c++) begin
        tick();
        if (ack2 !== 2'b00) begin
          e = sbq.pop_front();
          if (ack2 !== e.ack[1:0]) begin fails++; $display("FAIL wr_ack got %b want %b", ack2, e.ack[1:0]); end
          tests++;
          if (gnt2 !== e.gid) begin fails++; $display("FAIL wr_gnt got %0d want %0d", gnt2, e.gid); end
          tests++;
          if (mwe2 !== e.we) begin fails++; $display("FAIL wr_mem_we got %b want %b", mwe2, e.we); end
          tests++;
          if (ma2 !== e.a) begin fails++; $display("FAIL wr_mem_a got %h want %h", ma2, e.a); end
          tests++;
          if (e.we) begin
            if (mwd2 !== e.wd) begin fails++; $display("FAIL wr_mem_wd got %h want %h", mwd2, e.wd); end
          end else begin
            if (rdata2 !== e.rd) begin fails++; $display("FAIL wr_readback got %h want %h", rdata2, e.rd); end
          end
          tests++;
          req2 = req2 & ~ack2;
        end
      end
      if (sbq.size() != 0) begin fails++; $display("FAIL wr_timeout pending %0d want 0", sbq.size()); sbq.delete(); end
      tests++;
      if (pass == 0) begin
        tick();
        if (mwe2 !== 1'b0) begin fails++; $display("FAIL wr_we_pulse got %b want 0", mwe2); end
        tests++;
        if (ram2[4] !== 32'h12345678) begin fails++; $display("FAIL wr_ram got %h want 12345678", ram2[4]); end
        tests++;
        we2 = 2'b00; req2 = 2'b10;
        sbq.push_back(mk(4'b0010, 3'd1, 1'b0, 32'd4, 32'd0, 32'h12345678));
      end
    end
  endtask

  task automatic test_repeat();
    logic [1:0] pat [3];
    pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b01;
    addr2[31:0] = 32'd8; we2 = 2'b00; req2 = 2'b01;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ack2 !== pat[c]) begin fails++; $display("FAIL repeat_ack[%0d] got %b want %b", c, ack2, pat[c]); end
      tests++;
    end
    req2 = 2'b00;
    tick();
  endtask

  task automatic test_contention();
    int idle;
    int cyc;
    idle = 0; cyc = 0;
    @(negedge clk);
    reset = 1'b1;
    addr2 = {32'd4, 32'd8}; we2 = 2'b00; req2 = 2'b11;
    for (int k = 0; k < 2; k++) begin
      sbq.push_back(mk(4'b0001, 3'd0, 1'b0, 32'd8, 32'd0, 32'hDEADBEEF));
      sbq.push_back(mk(4'b0010, 3'd1, 1'b0, 32'd4, 32'd0, 32'h12345678));
    end
    #2 reset = 1'b0;
    for (int c = 0; c < 8 && sbq.size() != 0; c++) begin
      tick();
      cyc++;
      if (ack2 !== 2'b00) begin
        e = sbq.pop_front();
        if (ack2 !== e.ack[1:0]) begin fails++; $display("FAIL cont_ack got %b want %b", ack2, e.ack[1:0]); end
        tests++;
        if (gnt2 !== e.gid) begin fails++; $display("FAIL cont_gnt got %0d want %0d", gnt2, e.gid); end
        tests++;
        if (rdata2 !== e.rd) begin fails++; $display("FAIL cont_rdata got %h want %h", rdata2, e.rd); end
        tests++;
      end else begin
        idle++;
      end
    end
    req2 = 2'b00;
    if (sbq.size() != 0) begin fails++; $display("FAIL cont_timeout pending %0d want 0", sbq.size()); sbq.delete(); end
    tests++;
    if (idle != 0) begin fails++; $display("FAIL cont_idle got %0d idle cycles want 0", idle); end
    tests++;
    tick();
  endtask

  task automatic test_isolation();
    addr2[31:0] = 32'd12; wdata2[31:0] = 32'hA5A5A5A5; we2 = 2'b01; req2 = 2'b01;
    sbq.push_back(mk(4'b0001, 3'd0, 1'b1, 32'd12, 32'hA5A5A5A5, 32'd0));
    tick();
    addr2[31:0] = 32'd20; wdata2[31:0] = 32'hFFFF0000; req2 = 2'b00;
    #1;
    if (ack2 !== 2'b00) begin
      e = sbq.pop_front();
      if (ma2 !== e.a) begin fails++; $display("FAIL iso_mem_a got %h want %h", ma2, e.a); end
      tests++;
      if (mwd2 !== e.wd) begin fails++; $display("FAIL iso_mem_wd got %h want %h", mwd2, e.wd); end
      tests++;
      if (mwe2 !== e.we) begin fails++; $display("FAIL iso_mem_we got %b want %b", mwe2, e.we); end
      tests++;
    end
    if (sbq.size() != 0) begin fails++; $display("FAIL iso_no_ack pending %0d want 0", sbq.size()); sbq.delete(); end
    tests++;
    tick();
    if (ram2[12] !== 32'hA5A5A5A5) begin fails++; $display("FAIL iso_ram12 got %h want a5a5a5a5", ram2[12]); end
    tests++;
    if (ram2[20] !== 32'd0) begin fails++; $display("FAIL iso_ram20 got %h want 0", ram2[20]); end
    tests++;
    we2 = 2'b00;
  endtask

  task automatic test_reset_mid();
    ram2[16] = 32'h11111111;
    addr2[63:32] = 32'd16; wdata2[63:32] = 32'h22222222; we2 = 2'b10; req2 = 2'b10;
    tick();
    if (mwe2 !== 1'b1) begin fails++; $display("FAIL rstmid_pre_we got %b want 1", mwe2); end
    tests++;
    #2 reset = 1'b1;
    #1;
    if (mwe2 !== 1'b0) begin fails++; $display("FAIL rstmid_mem_we got %b want 0", mwe2); end
    tests++;
    if (ack2 !== 2'b00) begin fails++; $display("FAIL rstmid_ack got %b want 00", ack2); end
    tests++;
    if (busy2 !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy2); end
    tests++;
    req2 = 2'b00; we2 = 2'b00;
    tick();
    if (ram2[16] !== 32'h11111111) begin fails++; $display("FAIL rstmid_ram got %h want 11111111", ram2[16]); end
    tests++;
    addr2 = {32'd4, 32'd0}; req2 = 2'b11;
    sbq.push_back(mk(4'b0001, 3'd0, 1'b0, 32'd0, 32'd0, 32'hC0FFEE00));
    sbq.push_back(mk(4'b0010, 3'd1, 1'b0, 32'd4, 32'd0, 32'h12345678));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6 && sbq.size() != 0; c++) begin
      tick();
      if (ack2 !== 2'b00) begin
        e = sbq.pop_front();
        if (ack2 !== e.ack[1:0]) begin fails++; $display("FAIL rstmid_order got %b want %b", ack2, e.ack[1:0]); end
        tests++;
        if (rdata2 !== e.rd) begin fails++; $display("FAIL rstmid_rdata got %h want %h", rdata2, e.rd); end
        tests++;
        req2 = req2 & ~ack2;
      end
    end
    if (sbq.size() != 0) begin fails++; $display("FAIL rstmid_timeout pending %0d want 0", sbq.size()); sbq.delete(); end
    tests++;
    req2 = 2'b00;
    tick();
  endtask

  task automatic test_rotation4();
    int n;
    int idle;
    logic [2:0] order [6];
    n = 0; idle = 0;
    order[0] = 3'd1; order[1] = 3'd3; order[2] = 3'd1;
    order[3] = 3'd2; order[4] = 3'd3; order[5] = 3'd1;
    do_reset();
    addr4 = {32'd12, 32'd8, 32'd4, 32'd0}; we4 = 4'b0000; req4 = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      sbq.push_back(mk(4'b0001 << order[k], order[k], 1'b0, {27'd0, order[k], 2'b00}, 32'd0,
                       32'h100 + {29'd0, order[k]}));
    end
    for (int c = 0; c < 12 && sbq.size() != 0; c++) begin
      tick();
      if (ack4 !== 4'b0000) begin
        e = sbq.pop_front();
        n++;
        if (ack4 !== e.ack) begin fails++; $display("FAIL rot_ack[%0d] got %b want %b", n, ack4, e.ack); end
        tests++;
        if (gnt4 !== e.gid) begin fails++; $display("FAIL rot_gnt[%0d] got %0d want %0d", n, gnt4, e.gid); end
        tests++;
        if (rdata4 !== e.rd) begin fails++; $display("FAIL rot_rdata[%0d] got %h want %h", n, rdata4, e.rd); end
        tests++;
        if (ack4[2]) req4[2] = 1'b0;
        if (n == 2) req4[2] = 1'b1;
      end else begin
        idle++;
      end
    end
    req4 = 4'b0000;
    if (sbq.size() != 0) begin fails++; $display("FAIL rot_timeout pending %0d want 0", sbq.size()); sbq.delete(); end
    tests++;
    if (idle != 0) begin fails++; $display("FAIL rot_idle got %0d idle cycles want 0", idle); end
    tests++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram2[i] = 32'd0;
      ram4[i] = 32'd0;
    end
    ram2[0] = 32'hC0FFEE00;
    for (int i = 0; i < 4; i++) ram4[4*i] = 32'h100 + i;
    test_reset();
    test_single_read();
    test_write_read();
    test_repeat();
    test_contention();
    test_isolation();
    test_reset_mid();
    test_rotation4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
